// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among four functional units,
// with a one-cycle registered {tag, data} broadcast to the snooping consumers.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int PW     = TAG_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*PW-1:0] req_payload,
  output logic [NUM_REQ-1:0]    grant,
  output logic [PW-1:0]         cdb_out,
  output logic                  cdb_en,
  output logic                  tag_err
);

  logic [1:0]    rr_ptr;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          found;
  logic [PW-1:0] win_payload;

  // Search upward from rr_ptr, wrapping mod 4; rst and flush suppress any grant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rr_ptr + 2'(k);
        if (!found && req[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  assign grant       = found ? (NUM_REQ'(1) << winner) : '0;
  assign win_payload = req_payload[winner*PW +: PW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      cdb_en  <= 1'b0;
      cdb_out <= '0;
      tag_err <= 1'b0;
    end else if (flush) begin
      rr_ptr <= '0;
      cdb_en <= 1'b0;
    end else if (found) begin
      rr_ptr  <= winner + 2'd1;
      cdb_out <= win_payload;
      cdb_en  <= 1'b1;
      // Tag 0 means "ready" to the stations, so it must never appear on the bus.
      if (win_payload[PW-1:DATA_W] == '0) tag_err <= 1'b1;
    end else begin
      cdb_en <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common data bus arbiter and broadcast register, directly downstream of the ALU reservation stations and the other functional-unit stations (load/store, branch, multiply).
- Each cycle, grants the bus to one requesting unit using round-robin priority.
- Registers the winner's {ROB tag, result} and broadcasts it for one cycle on the CDB, where the reservation stations and the ROB snoop it.

Parameters:
- NUM_REQ, 4, number of requesting units. Fixed at 4; the round-robin pointer is 2 bits.
- TAG_W, 5, ROB tag width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline flush from the ROB.
- req  in  4  per-unit bus request (req_bus). Bit 0 is the ALU RS, bit 1 load/store, bit 2 branch, bit 3 multiply.
- req_payload  in  148  four 37-bit {tag[36:32], data[31:0]} fields. Unit i occupies bits [37*i+36 : 37*i]. The ALU RS connects its cdb_out[36:0].
- grant  out  4  one-hot grant, combinational, same cycle as req (bus_granted).
- cdb_out  out  37  registered {tag, data} broadcast (cdb_in of consumers).
- cdb_en  out  1  registered broadcast valid.
- tag_err  out  1  sticky flag: a tag of 0 was broadcast.

Behaviour:
- Reset (async, rst=1) drives:
  - rr_ptr = 0
  - cdb_en = 0
  - cdb_out = 0
  - tag_err = 0
- While rst is high, grant = 0 (combinational gate).
- Arbitration (combinational):
  - Search req bits starting at rr_ptr, upward modulo 4.
  - The first asserted bit wins; grant has that one bit set.
  - If req = 0, grant = 0.
  - grant is never more than one-hot.
  - A granted unit does not depend on grant being held: it frees its slot at the same posedge.
- Pointer update at posedge:
  - If a grant is issued, rr_ptr <= (winner + 1) mod 4.
  - Otherwise rr_ptr is unchanged.
- Broadcast register:
  - If a grant is issued in cycle N: cdb_out <= winner's payload, and cdb_en <= 1 in cycle N+1.
  - If no grant is issued: cdb_en <= 0, and cdb_out holds its previous value.
  - Latency from req to visible broadcast is 1 cycle.
  - cdb_en is high for exactly one cycle per grant. Back-to-back grants give cdb_en high on consecutive cycles, with a new payload each cycle.
- Flush (synchronous):
  - In a cycle where flush = 1, grant is forced to 0.
  - At that posedge: cdb_en <= 0 and rr_ptr <= 0. cdb_out holds.
  - A broadcast already visible in the flush cycle (cdb_en = 1 from the prior grant) remains visible for that cycle only. Consumers discard it under flush.
- tag_err:
  - Set at posedge when a grant is issued and the winner's tag = 0. Tag 0 means "data ready" and is illegal on the CDB.
  - The broadcast still proceeds.
  - Cleared only by rst; flush does not clear it.
- Simultaneous events:
  - All four units requesting: exactly one wins per cycle. Each unit is granted within 4 cycles of continuous request (no starvation).
  - flush together with rst: rst dominates.
  - rst asserted mid-broadcast: cdb_en drops to 0 immediately, without waiting for a clock edge.
- No internal buffering: an ungranted unit holds req and its payload until it is granted. Payload is sampled only in the grant cycle.

Test Plan:
- Reset state: after rst, set req = 4'b0001 with unit 0 payload tag = 5'd3, data = 32'hDEADBEEF. Required: grant = 4'b0001 the same cycle; next cycle cdb_en = 1 and cdb_out = {5'd3, 32'hDEADBEEF}; rr_ptr = 1.
- Round-robin: with rr_ptr = 0, hold req = 4'b1111 for 5 cycles. Required: grant sequence 0001, 0010, 0100, 1000, 0001, with cdb_en high on 5 consecutive cycles and each payload matching its winner's tag.
- Pointer skip: with rr_ptr = 1, set req = 4'b1001. Required: grant = 4'b1000, then rr_ptr = 0. Next cycle with req = 4'b1001, grant = 4'b0001.
- Idle hold: after a broadcast of tag 7, drop req to 0. Required: cdb_en = 0 next cycle, cdb_out still shows tag 7, rr_ptr unchanged.
- Flush: assert flush with req = 4'b0110. Required: grant = 0 that cycle; next cycle cdb_en = 0 and rr_ptr = 0. The following cycle with req = 4'b0110 gives grant = 4'b0010.
- Tag error and async reset: grant unit 2 with tag = 0. Required: broadcast occurs and tag_err = 1, which stays set through a flush. Pulse rst between clock edges: cdb_en and tag_err go to 0 immediately.
